// File: rtl/can_ifs_overload_ctrl.sv
// can_ifs_overload_ctrl: CAN interframe-space / overload-frame controller.
// Follows the bus from end-of-frame through intermission, overload frames
// (own flag, superposition, delimiter) and bus idle. It flags start-of-frame,
// requests the dominant overload flag and caps consecutive overload frames.
// Optional feature: define SUSPEND_TX_EN to add the error-passive
// suspend-transmission phase that follows intermission.
module can_ifs_overload_ctrl #(
    parameter int unsigned INTERMISSION_BITS = 3,
    parameter int unsigned OVL_FLAG_BITS     = 6,
    parameter int unsigned OVL_SUPERPOS_MAX  = 7,
    parameter int unsigned OVL_DELIM_BITS    = 8,
    parameter int unsigned MAX_OVERLOADS     = 2,
    parameter int unsigned SUSPEND_BITS      = 8
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       samplePoint,
    input  logic       canRX,
    input  logic       frameReady,
    input  logic       isError,
    input  logic       errorPassive,
    output logic       isStart,
    output logic       endOverload,
    output logic       overloadActive,
    output logic       txDominant,
    output logic       overloadErr,
    output logic       overloadLimit,
    output logic       busIdle,
    output logic       suspendActive,
    output logic [1:0] overloadCount
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // One shared bit counter serves every phase; it is sized for the longest one.
    localparam int unsigned CNT_MAX = max2(max2(INTERMISSION_BITS, OVL_FLAG_BITS),
                                           max2(max2(OVL_SUPERPOS_MAX, OVL_DELIM_BITS),
                                                SUSPEND_BITS));
    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] IFS_END      = CNT_W'(INTERMISSION_BITS);
    localparam logic [CNT_W-1:0] IFS_SOF      = CNT_W'(INTERMISSION_BITS - 32'd1);
    localparam logic [CNT_W-1:0] FLAG_END     = CNT_W'(OVL_FLAG_BITS);
    localparam logic [CNT_W-1:0] SUPERPOS_END = CNT_W'(OVL_SUPERPOS_MAX);
    localparam logic [CNT_W-1:0] DELIM_END    = CNT_W'(OVL_DELIM_BITS);
`ifdef SUSPEND_TX_EN
    localparam logic [CNT_W-1:0] SUSP_END     = CNT_W'(SUSPEND_BITS);
`endif

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WAIT_FRAME   = 3'd1,
        ST_INTERMISSION = 3'd2,
        ST_OVL_FLAG     = 3'd3,
        ST_OVL_WAIT     = 3'd4,
        ST_OVL_DELIM    = 3'd5
`ifdef SUSPEND_TX_EN
        , ST_SUSPEND    = 3'd6
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_s;
    logic [1:0]       ovl_cnt_q, ovl_cnt_d;
    logic             tx_dominant_q, tx_dominant_d;
    logic             ovl_active_q, ovl_active_d;
    logic             is_start_q, is_start_d;
    logic             end_ovl_q, end_ovl_d;
    logic             ovl_err_q, ovl_err_d;
    logic             ovl_limit_q, ovl_limit_d;
    logic             bus_idle_q, bus_idle_d;
    logic             suspend_q, suspend_d;

`ifndef SUSPEND_TX_EN
    // Without the suspend phase the error-passive level has no effect.
    logic err_passive_unused_s;
    assign err_passive_unused_s = errorPassive;
`endif

    // Next state, counters and outputs; isError outranks frameReady, which outranks samplePoint.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ovl_cnt_d     = ovl_cnt_q;
        tx_dominant_d = tx_dominant_q;
        ovl_active_d  = ovl_active_q;
        is_start_d    = 1'b0;
        end_ovl_d     = 1'b0;
        ovl_err_d     = 1'b0;
        ovl_limit_d   = 1'b0;
        cnt_inc_s     = cnt_q + CNT_ONE;

        if (isError) begin
            state_d       = ST_WAIT_FRAME;
            cnt_d         = CNT_ZERO;
            ovl_cnt_d     = 2'd0;
            tx_dominant_d = 1'b0;
            ovl_active_d  = 1'b0;
        end else if (frameReady && (state_q == ST_WAIT_FRAME)) begin
            state_d = ST_INTERMISSION;
            cnt_d   = CNT_ZERO;
        end else if (samplePoint) begin
            case (state_q)
                ST_IDLE: begin
                    if (!canRX) begin
                        is_start_d = 1'b1;
                        ovl_cnt_d  = 2'd0;
                        state_d    = ST_WAIT_FRAME;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT_FRAME: begin
                    state_d = ST_WAIT_FRAME;
                end
                ST_INTERMISSION: begin
                    if (canRX) begin
                        if (cnt_inc_s == IFS_END) begin
                            cnt_d = CNT_ZERO;
`ifdef SUSPEND_TX_EN
                            state_d = errorPassive ? ST_SUSPEND : ST_IDLE;
`else
                            state_d = ST_IDLE;
`endif
                        end else begin
                            cnt_d = cnt_inc_s;
                        end
                    end else if (cnt_q == IFS_SOF) begin
                        // Dominant in the last intermission bit is taken as SOF.
                        is_start_d = 1'b1;
                        ovl_cnt_d  = 2'd0;
                        state_d    = ST_WAIT_FRAME;
                    end else if (32'(ovl_cnt_q) < MAX_OVERLOADS) begin
                        state_d       = ST_OVL_FLAG;
                        cnt_d         = CNT_ZERO;
                        tx_dominant_d = 1'b1;
                        ovl_active_d  = 1'b1;
                    end else begin
                        ovl_limit_d = 1'b1;
                        state_d     = ST_WAIT_FRAME;
                    end
                end
                ST_OVL_FLAG: begin
                    // Own flag length is fixed; the bus level is irrelevant here.
                    if (cnt_inc_s == FLAG_END) begin
                        tx_dominant_d = 1'b0;
                        cnt_d         = CNT_ZERO;
                        state_d       = ST_OVL_WAIT;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                ST_OVL_WAIT: begin
                    if (!canRX) begin
                        if (cnt_inc_s == SUPERPOS_END) begin
                            ovl_err_d    = 1'b1;
                            ovl_active_d = 1'b0;
                            cnt_d        = CNT_ZERO;
                            state_d      = ST_WAIT_FRAME;
                        end else begin
                            cnt_d = cnt_inc_s;
                        end
                    end else begin
                        // First recessive bit is already delimiter bit one.
                        cnt_d   = CNT_ONE;
                        state_d = ST_OVL_DELIM;
                    end
                end
                ST_OVL_DELIM: begin
                    if (!canRX) begin
                        ovl_err_d    = 1'b1;
                        ovl_active_d = 1'b0;
                        cnt_d        = CNT_ZERO;
                        state_d      = ST_WAIT_FRAME;
                    end else if (cnt_inc_s == DELIM_END) begin
                        end_ovl_d    = 1'b1;
                        ovl_active_d = 1'b0;
                        ovl_cnt_d    = (ovl_cnt_q == 2'd3) ? 2'd3 : (ovl_cnt_q + 2'd1);
                        cnt_d        = CNT_ZERO;
                        state_d      = ST_INTERMISSION;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
`ifdef SUSPEND_TX_EN
                ST_SUSPEND: begin
                    if (!canRX) begin
                        is_start_d = 1'b1;
                        ovl_cnt_d  = 2'd0;
                        cnt_d      = CNT_ZERO;
                        state_d    = ST_WAIT_FRAME;
                    end else if (cnt_inc_s == SUSP_END) begin
                        cnt_d   = CNT_ZERO;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
`endif
                default: begin
                    state_d       = ST_IDLE;
                    cnt_d         = CNT_ZERO;
                    tx_dominant_d = 1'b0;
                    ovl_active_d  = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        bus_idle_d = (state_d == ST_IDLE);
`ifdef SUSPEND_TX_EN
        suspend_d  = (state_d == ST_SUSPEND);
`else
        suspend_d  = 1'b0;
`endif
    end

    // State, counters and all outputs are registered together.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q       <= ST_IDLE;
            cnt_q         <= CNT_ZERO;
            ovl_cnt_q     <= 2'd0;
            tx_dominant_q <= 1'b0;
            ovl_active_q  <= 1'b0;
            is_start_q    <= 1'b0;
            end_ovl_q     <= 1'b0;
            ovl_err_q     <= 1'b0;
            ovl_limit_q   <= 1'b0;
            bus_idle_q    <= 1'b1;
            suspend_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ovl_cnt_q     <= ovl_cnt_d;
            tx_dominant_q <= tx_dominant_d;
            ovl_active_q  <= ovl_active_d;
            is_start_q    <= is_start_d;
            end_ovl_q     <= end_ovl_d;
            ovl_err_q     <= ovl_err_d;
            ovl_limit_q   <= ovl_limit_d;
            bus_idle_q    <= bus_idle_d;
            suspend_q     <= suspend_d;
        end
    end

    assign isStart        = is_start_q;
    assign endOverload    = end_ovl_q;
    assign overloadActive = ovl_active_q;
    assign txDominant     = tx_dominant_q;
    assign overloadErr    = ovl_err_q;
    assign overloadLimit  = ovl_limit_q;
    assign busIdle        = bus_idle_q;
    assign suspendActive  = suspend_q;
    assign overloadCount  = ovl_cnt_q;

endmodule
